// File: rtl/clkdiv_ratio_ctrl.sv
// Sequences run-time ratio changes for one ClkDiv: gate enable, load ratio, wait for lock.
// Optional range checking of requested ratios is enabled by defining CLKDIV_CTRL_RANGE_EN.
module clkdiv_ratio_ctrl #(
  parameter int DIV_WIDTH   = 8,
  parameter int GATE_CYCLES = 4,
  parameter int RST_RATIO   = 1,
  parameter int MIN_RATIO   = 2,
  parameter int MAX_RATIO   = 128
) (
  input  logic                 I_ref_clk,
  input  logic                 I_rst_n,
  input  logic                 I_cfg_valid,
  input  logic [DIV_WIDTH-1:0] I_cfg_ratio,
  output logic                 O_cfg_ready,
  output logic                 O_cfg_done,
  output logic                 O_cfg_err,
  output logic [DIV_WIDTH-1:0] O_div_ratio,
  output logic                 O_clk_en,
  output logic                 O_locked,
  output logic                 O_busy
);

  typedef enum logic [1:0] {IDLE, GATE, LOAD, LOCK} state_t;

  localparam int CW = DIV_WIDTH + 1;
  localparam logic [CW-1:0]        GATE_LOAD = CW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0]        MIN_W     = CW'(MIN_RATIO);
  localparam logic [CW-1:0]        MAX_W     = CW'(MAX_RATIO);
  localparam logic [DIV_WIDTH-1:0] RST_W     = DIV_WIDTH'(RST_RATIO);
`ifdef CLKDIV_CTRL_RANGE_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  state_t               state, state_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [DIV_WIDTH-1:0] pend_ratio, pend_nx;
  logic [DIV_WIDTH-1:0] ratio_q, ratio_nx;
  logic                 clk_en_q, clk_en_nx;
  logic                 locked_q, locked_nx;
  logic                 done_q, done_nx;
  logic                 err_q, err_nx;
  logic                 accept;
  logic                 range_ok;
  logic [CW-1:0]        lock_load;

  assign accept   = I_cfg_valid && (state == IDLE);
  assign range_ok = !RANGE_EN ||
                    (({1'b0, I_cfg_ratio} >= MIN_W) && ({1'b0, I_cfg_ratio} <= MAX_W));

  // Two divided periods of lock time; bypass ratios (0 and 1) need only a token wait.
  assign lock_load = (pend_ratio <= DIV_WIDTH'(1)) ? CW'(1)
                                                    : ({pend_ratio, 1'b0} - CW'(1));

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    pend_nx   = pend_ratio;
    ratio_nx  = ratio_q;
    clk_en_nx = clk_en_q;
    locked_nx = locked_q;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          pend_nx = I_cfg_ratio;
          if (!range_ok) begin
            err_nx = 1'b1;
          end else if (I_cfg_ratio == ratio_q) begin
            done_nx = 1'b1;
          end else begin
            state_nx  = GATE;
            clk_en_nx = 1'b0;
            locked_nx = 1'b0;
            cnt_nx    = GATE_LOAD;
          end
        end
      end
      GATE: begin
        if (cnt == '0) begin
          state_nx  = LOAD;
          ratio_nx  = pend_ratio;
          clk_en_nx = 1'b1;
          cnt_nx    = lock_load;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      LOAD: begin
        state_nx = LOCK;
      end
      LOCK: begin
        if (cnt == '0) begin
          state_nx  = IDLE;
          locked_nx = 1'b1;
          done_nx   = 1'b1;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_ratio <= '0;
      ratio_q    <= RST_W;
      clk_en_q   <= 1'b1;
      locked_q   <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      pend_ratio <= pend_nx;
      ratio_q    <= ratio_nx;
      clk_en_q   <= clk_en_nx;
      locked_q   <= locked_nx;
      done_q     <= done_nx;
      err_q      <= err_nx;
    end
  end

  assign O_cfg_ready = (state == IDLE);
  assign O_busy      = (state != IDLE);
  assign O_cfg_done  = done_q;
  assign O_cfg_err   = err_q;
  assign O_div_ratio = ratio_q;
  assign O_clk_en    = clk_en_q;
  assign O_locked    = locked_q;

endmodule
